// File: rtl/sm5_pkg.sv
// SM5xx timebase shared types and defaults.
// Halt states, variant defaults and the wake vector used by the core.
package sm5_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    WAKE = 2'd2
  } halt_state_t;

  localparam int SM5_DIV_WIDTH   = 15;
  localparam int SM5_NUM_COMMONS = 4;
  localparam int SM5_STROBE_TAP  = 10;
  localparam int SM5_F1_TAP      = 14;
  localparam int SM5_F4_TAP      = 11;

  // PC loaded by the core on wake_pulse (page 1, 0, step 00)
  localparam logic [11:0] SM5_WAKE_PC = 12'b01_0000_000000;

endpackage

// File: rtl/sm5_common_strobe.sv
// LCD common strobe: rising-edge detect on a divider tap and a
// one-hot rotator that walks the active common line.
module sm5_common_strobe
  import sm5_pkg::*;
#(
  parameter int NUM_COMMONS = SM5_NUM_COMMONS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic                   tap,
  output logic [NUM_COMMONS-1:0] lcd_h,
  output logic                   lcd_frame
);

  logic prev_tap;
  logic tap_rise;
  logic [NUM_COMMONS-1:0] h_rot;

  assign tap_rise = tap & ~prev_tap;

  // Shift form of a rotate; degenerates to a hold when NUM_COMMONS is 1
  assign h_rot = (lcd_h << 1) | (lcd_h >> (NUM_COMMONS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_tap  <= 1'b0;
      lcd_h     <= NUM_COMMONS'(1);
      lcd_frame <= 1'b0;
    end else if (clk_en) begin
      prev_tap  <= tap;
      lcd_frame <= tap_rise & lcd_h[NUM_COMMONS-1];
      if (tap_rise) begin
        lcd_h <= h_rot;
      end
    end
  end

endmodule

// File: rtl/sm5_timebase.sv
// SM5xx timebase: free-running divider, 1 s gamma latch, F1/F4 taps,
// LCD common strobe and the CEND halt/wake sequencer.
module sm5_timebase
  import sm5_pkg::*;
#(
  parameter int DIV_WIDTH   = SM5_DIV_WIDTH,
  parameter int NUM_COMMONS = SM5_NUM_COMMONS,
  parameter int STROBE_TAP  = SM5_STROBE_TAP,
  parameter int F1_TAP      = SM5_F1_TAP,
  parameter int F4_TAP      = SM5_F4_TAP,
  parameter bit WAKE_ON_K   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic                   div_reset,
  input  logic                   gamma_clear,
  input  logic                   halt_req,
  input  logic [3:0]             input_k,
  output logic [DIV_WIDTH-1:0]   divider,
  output logic                   gamma,
  output logic                   f1,
  output logic                   f4,
  output logic                   tick_1s,
  output logic [NUM_COMMONS-1:0] lcd_h,
  output logic                   lcd_frame,
  output logic                   halted,
  output logic                   wake_pulse
);

  logic [3:0]  k_m;
  logic [3:0]  k_s;
  logic        wake_src;
  logic        strobe_tap;
  halt_state_t state;

  // K pins are asynchronous; synchronise on every clk, not just enables
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_m <= 4'd0;
      k_s <= 4'd0;
    end else begin
      k_m <= input_k;
      k_s <= k_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divider <= '0;
      tick_1s <= 1'b0;
      gamma   <= 1'b0;
    end else if (clk_en) begin
      divider <= div_reset ? '0 : divider + 1'b1;
      tick_1s <= ~div_reset & (&divider);
      gamma   <= tick_1s | (gamma & ~gamma_clear);
    end
  end

  assign f1 = divider[F1_TAP];
  assign f4 = divider[F4_TAP];

  // A divider clear forces the tap low so it can never fake an edge
  assign strobe_tap = divider[STROBE_TAP] & ~div_reset;

  sm5_common_strobe #(
    .NUM_COMMONS(NUM_COMMONS)
  ) u_strobe (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .tap      (strobe_tap),
    .lcd_h    (lcd_h),
    .lcd_frame(lcd_frame)
  );

  assign wake_src = tick_1s | (WAKE_ON_K & (|k_s));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      halted     <= 1'b0;
      wake_pulse <= 1'b0;
    end else if (clk_en) begin
      unique case (state)
        RUN: begin
          wake_pulse <= 1'b0;
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            halted <= 1'b0;
          end
        end
        HALT: begin
          halted <= 1'b1;
          if (wake_src) begin
            state      <= WAKE;
            wake_pulse <= 1'b1;
          end else begin
            wake_pulse <= 1'b0;
          end
        end
        WAKE: begin
          state      <= RUN;
          halted     <= 1'b0;
          wake_pulse <= 1'b0;
        end
        default: begin
          state      <= RUN;
          halted     <= 1'b0;
          wake_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm5_timebase.sv
// Scoreboard bench for sm5_timebase: two variants share one stimulus
// stream and are compared against a behavioural model each clock.
module tb_sm5_timebase;

  logic       clk;
  logic       reset_n;
  logic       clk_en;
  logic       div_reset;
  logic       gamma_clear;
  logic       halt_req;
  logic [3:0] input_k;

  logic [5:0] a_div, b_div;
  logic       a_gam, b_gam, a_f1, b_f1, a_f4, b_f4, a_tick, b_tick;
  logic [3:0] a_h;
  logic [2:0] b_h;
  logic       a_frm, b_frm, a_hlt, b_hlt, a_wk, b_wk;

  sm5_timebase #(
    .DIV_WIDTH(6), .NUM_COMMONS(4), .STROBE_TAP(2),
    .F1_TAP(5), .F4_TAP(3), .WAKE_ON_K(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .div_reset(div_reset), .gamma_clear(gamma_clear),
    .halt_req(halt_req), .input_k(input_k),
    .divider(a_div), .gamma(a_gam), .f1(a_f1), .f4(a_f4),
    .tick_1s(a_tick), .lcd_h(a_h), .lcd_frame(a_frm),
    .halted(a_hlt), .wake_pulse(a_wk)
  );

  sm5_timebase #(
    .DIV_WIDTH(6), .NUM_COMMONS(3), .STROBE_TAP(2),
    .F1_TAP(5), .F4_TAP(3), .WAKE_ON_K(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .div_reset(div_reset), .gamma_clear(gamma_clear),
    .halt_req(halt_req), .input_k(input_k),
    .divider(b_div), .gamma(b_gam), .f1(b_f1), .f4(b_f4),
    .tick_1s(b_tick), .lcd_h(b_h), .lcd_frame(b_frm),
    .halted(b_hlt), .wake_pulse(b_wk)
  );

  typedef struct {
    logic [5:0] div;
    logic       gamma;
    logic       tick;
    logic       frame;
    logic       prev;
    logic       halted;
    logic       wake;
    logic [7:0] h;
    int         st;
    logic [3:0] k1;
    logic [3:0] k2;
  } mst_t;

  typedef struct {
    mst_t a;
    mst_t b;
  } exp_t;

  mst_t ma, mb;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mst_t mreset();
    mst_t r;
    r.div = '0; r.gamma = 0; r.tick = 0; r.frame = 0; r.prev = 0;
    r.halted = 0; r.wake = 0; r.h = 8'd1; r.st = 0;
    r.k1 = '0; r.k2 = '0;
    return r;
  endfunction

  function automatic mst_t mstep(mst_t s, int nc, bit wok);
    mst_t n;
    logic tap, rise;
    n = s;
    n.k1 = input_k;
    n.k2 = s.k1;
    if (clk_en) begin
      tap = s.div[2] & ~div_reset;
      rise = tap & ~s.prev;
      n.div = div_reset ? 6'd0 : s.div + 6'd1;
      n.tick = !div_reset && s.div == 6'd63;
      n.gamma = s.tick | (s.gamma & ~gamma_clear);
      n.prev = tap;
      n.frame = rise && s.h[nc-1];
      if (rise) n.h = s.h[nc-1] ? 8'd1 : s.h << 1;
      case (s.st)
        0: if (halt_req) n.st = 1;
        1: if (s.tick || (wok && s.k2 != 4'd0)) n.st = 2;
        default: n.st = 0;
      endcase
      n.halted = n.st != 0;
      n.wake = n.st == 2;
    end
    return n;
  endfunction

  task automatic cmp(string p, mst_t e, logic [5:0] dv, logic g,
                     logic f1v, logic f4v, logic tk, logic [7:0] h,
                     logic fr, logic hl, logic wk);
    chk({p, "div"}, 32'(dv), 32'(e.div));
    chk({p, "gamma"}, 32'(g), 32'(e.gamma));
    chk({p, "f1"}, 32'(f1v), 32'(e.div[5]));
    chk({p, "f4"}, 32'(f4v), 32'(e.div[3]));
    chk({p, "tick"}, 32'(tk), 32'(e.tick));
    chk({p, "lcd_h"}, 32'(h), 32'(e.h));
    chk({p, "frame"}, 32'(fr), 32'(e.frame));
    chk({p, "halted"}, 32'(hl), 32'(e.halted));
    chk({p, "wake"}, 32'(wk), 32'(e.wake));
  endtask

  task automatic step();
    exp_t e;
    ma = mstep(ma, 4, 1'b1);
    mb = mstep(mb, 3, 1'b0);
    e.a = ma;
    e.b = mb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp("a_", e.a, a_div, a_gam, a_f1, a_f4, a_tick, {4'd0, a_h},
        a_frm, a_hlt, a_wk);
    cmp("b_", e.b, b_div, b_gam, b_f1, b_f4, b_tick, {5'd0, b_h},
        b_frm, b_hlt, b_wk);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(logic [5:0] d);
    int guard;
    guard = 0;
    while (ma.div != d && guard < 200) begin
      step();
      guard++;
    end
    if (ma.div != d) chk("run_to_bound", 32'(ma.div), 32'(d));
  endtask

  initial begin
    reset_n = 1'b0;
    clk_en = 1'b1;
    div_reset = 1'b0;
    gamma_clear = 1'b0;
    halt_req = 1'b0;
    input_k = 4'd0;
    ma = mreset();
    mb = mreset();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_div", 32'(a_div), 0);
    chk("rst_lcd_h", 32'(a_h), 1);
    chk("rst_halted", 32'(a_hlt), 0);
    chk("rst_tick", 32'(a_tick), 0);
    reset_n = 1'b1;

    // first wrap after exactly 64 enables
    steps(63);
    chk("no_tick63", 32'(a_tick), 0);
    step();
    chk("tick64", 32'(a_tick), 1);
    gamma_clear = 1'b1;
    step();
    chk("gamma_set_wins", 32'(a_gam), 1);
    step();
    chk("gamma_cleared", 32'(a_gam), 0);
    gamma_clear = 1'b0;
    run_to(6'd0);
    chk("tick128", 32'(a_tick), 1);
    step();
    chk("gamma_after2", 32'(a_gam), 1);

    // divider clear at all-ones suppresses the tick
    run_to(6'd63);
    div_reset = 1'b1;
    step();
    div_reset = 1'b0;
    chk("dr63_div", 32'(a_div), 0);
    chk("dr63_tick", 32'(a_tick), 0);
    chk("dr63_gamma", 32'(a_gam), 1);
    run_to(6'd5);
    div_reset = 1'b1;
    step();
    div_reset = 1'b0;
    chk("dr5_div", 32'(a_div), 0);
    step();
    chk("dr5_div1", 32'(a_div), 1);
    step();
    chk("dr5_div2", 32'(a_div), 2);

    // strobe rotation over several frames
    steps(80);

    // halt, woken by the 1 s tick
    run_to(6'd10);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_tick_halted", 32'(a_hlt), 1);
    run_to(6'd0);
    step();
    chk("halt_tick_wake", 32'(a_wk), 1);
    step();
    chk("halt_tick_run", 32'(a_hlt), 0);

    // halt, woken by K (only variant a)
    run_to(6'd20);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    steps(3);
    input_k = 4'b0100;
    steps(4);
    run_to(6'd1);
    steps(2);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("k_held_halt", 32'(a_hlt), 1);
    step();
    chk("k_held_wake", 32'(a_wk), 1);
    steps(3);
    input_k = 4'd0;
    steps(4);

    // clock-enable gating freezes everything but the synchroniser
    clk_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      div_reset = i[0];
      halt_req = i[1];
      gamma_clear = 1'b1;
      input_k = 4'(i);
      step();
    end
    div_reset = 1'b0;
    halt_req = 1'b0;
    gamma_clear = 1'b0;
    input_k = 4'd0;
    clk_en = 1'b1;
    steps(20);

    // asynchronous reset in the middle of a halt
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    steps(2);
    chk("pre_rst_halted", 32'(a_hlt), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_halted_a", 32'(a_hlt), 0);
    chk("arst_lcd_h_a", 32'(a_h), 1);
    chk("arst_halted_b", 32'(b_hlt), 0);
    chk("arst_lcd_h_b", 32'(b_h), 1);
    chk("arst_div", 32'(a_div), 0);
    ma = mreset();
    mb = mreset();
    #2;
    reset_n = 1'b1;
    steps(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
